// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128/192/256 forward/inverse cipher, one round per clock
module aes_cipher_core #(
  parameter int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     decrypt,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             block_in,
  input  logic [0:128*(NR+1)-1]    keySchedule,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             block_out,
  output logic                     busy
);
  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_cipher_core: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} st_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // Field inverse as x^254, built from the squares x^2 .. x^128; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int k = 1; k < 8; k++) begin
      p = gm(p, p);
      r = gm(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] g;
    g = ginv(b);
    return g ^ rl(g, 1) ^ rl(g, 2) ^ rl(g, 3) ^ rl(g, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05);
  endfunction

  // Byte i of the state is row i%4, column i/4; byte 0 sits in the top bits.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*((i + 4*(i%4)) % 16) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = isbox(s[127-8*((i + 16 - 4*(i%4)) % 16) -: 8]);
    return o;
  endfunction

  // MixColumns with coefficients {2,3,1,1}; InvMixColumns with {e,b,d,9}.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] a [4];
    logic [7:0] m [4];
    m[0] = inv ? 8'h0e : 8'h02;
    m[1] = inv ? 8'h0b : 8'h03;
    m[2] = inv ? 8'h0d : 8'h01;
    m[3] = inv ? 8'h09 : 8'h01;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gm(m[0], a[r]) ^ gm(m[1], a[(r+1)%4])
                              ^ gm(m[2], a[(r+2)%4]) ^ gm(m[3], a[(r+3)%4]);
    end
    return o;
  endfunction

  st_t          st_q;
  logic [3:0]   rnd_q, kidx;
  logic         mode_q, out_valid_q, last;
  logic [127:0] state_q, out_q, blk_in, rk, ss, dec_b, enc_d, dec_d, round_d;

  assign blk_in = block_in;
  assign last   = st_q == FINAL;
  assign kidx   = st_q == IDLE  ? (decrypt ? 4'(NR) : 4'd0)
                : last          ? (mode_q ? 4'd0 : 4'(NR))
                : (mode_q ? 4'(NR) - rnd_q : rnd_q);
  assign rk      = keySchedule[128*kidx +: 128];
  assign ss      = sub_shift(state_q);
  assign enc_d   = (last ? ss : mix(ss, 1'b0)) ^ rk;
  assign dec_b   = inv_shift_sub(state_q) ^ rk;
  assign dec_d   = last ? dec_b : mix(dec_b, 1'b1);
  assign round_d = mode_q ? dec_d : enc_d;

  assign in_ready  = st_q == IDLE;
  assign busy      = st_q == ROUND || st_q == FINAL;
  assign out_valid = out_valid_q;
  assign block_out = out_q;

  // Control FSM and datapath: accept, run NR-1 full rounds, final round, hold result.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q        <= IDLE;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      state_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (in_valid) begin
          mode_q  <= decrypt;
          state_q <= blk_in ^ rk;
          rnd_q   <= 4'd1;
          st_q    <= ROUND;
        end
        ROUND: begin
          state_q <= round_d;
          rnd_q   <= rnd_q + 4'd1;
          if (rnd_q == 4'(NR - 1)) st_q <= FINAL;
        end
        FINAL: begin
          out_q       <= round_d;
          out_valid_q <= 1'b1;
          st_q        <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          st_q        <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_cipher_core.sv
// tb_aes_cipher_core: directed AES known-answer, timing, back-pressure, reset and stream checks
module tb_aes_cipher_core;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KUNG = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] TT   = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 0, reset = 1, decrypt = 0, out_ready = 1, iv4 = 0, iv6 = 0, iv8 = 0;
  logic [127:0] block_in = '0;
  logic [0:1919] k4 = '0, k6 = '0, k8 = '0;
  logic ir4, ir6, ir8, ov4, ov6, ov8, bz4, bz6, bz8;
  logic [127:0] bo4, bo6, bo8;
  logic ir, ov, bz;
  logic [127:0] bo;
  int sel = 4, total = 0, bad = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_cipher_core #(.NK(4)) u4 (.clk(clk), .reset(reset), .decrypt(decrypt), .in_valid(iv4),
    .in_ready(ir4), .block_in(block_in), .keySchedule(k4[0:1407]), .out_valid(ov4),
    .out_ready(out_ready), .block_out(bo4), .busy(bz4));
  aes_cipher_core #(.NK(6)) u6 (.clk(clk), .reset(reset), .decrypt(decrypt), .in_valid(iv6),
    .in_ready(ir6), .block_in(block_in), .keySchedule(k6[0:1663]), .out_valid(ov6),
    .out_ready(out_ready), .block_out(bo6), .busy(bz6));
  aes_cipher_core #(.NK(8)) u8 (.clk(clk), .reset(reset), .decrypt(decrypt), .in_valid(iv8),
    .in_ready(ir8), .block_in(block_in), .keySchedule(k8), .out_valid(ov8),
    .out_ready(out_ready), .block_out(bo8), .busy(bz8));

  always_comb begin
    ir = sel == 4 ? ir4 : sel == 6 ? ir6 : ir8;
    ov = sel == 4 ? ov4 : sel == 6 ? ov6 : ov8;
    bz = sel == 4 ? bz4 : sel == 6 ? bz6 : bz8;
    bo = sel == 4 ? bo4 : sel == 6 ? bo6 : bo8;
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from the generator-3 walk: p steps by *3, q by /3, q = p^-1.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [0:1919] expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [0:1919] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
      ks[32*i +: 32] = w[i];
    end
    return ks;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [0:1919] ks, input int nr);
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] t;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[8*i +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sb[s[(i + 4*(i%4)) % 16]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          t = u[4*c] ^ u[4*c+1] ^ u[4*c+2] ^ u[4*c+3];
          for (int j = 0; j < 4; j++) s[4*c+j] = u[4*c+j] ^ t ^ xt(u[4*c+j] ^ u[4*c+(j+1)%4]);
        end
      end else s = u;
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r + 8*i +: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iv(input logic v);
    iv4 = v && sel == 4;
    iv6 = v && sel == 6;
    iv8 = v && sel == 8;
  endtask

  task automatic send(input int s, input logic dec, input logic [127:0] blk, input logic [127:0] exp, input string tag);
    int n = 0, nb = 0;
    sel = s;
    decrypt = dec;
    block_in = blk;
    #1;
    chk({tag, " in_ready"}, ir, 1);
    set_iv(1);
    step();
    set_iv(0);
    while (!ov && n < 20) begin
      nb += int'(bz);
      step();
      n++;
    end
    chk({tag, " latency"}, n, s + 6);
    chk({tag, " busy"}, nb, s + 6);
    chk({tag, " result"}, bo, exp);
  endtask

  task automatic hs(input string tag);
    out_ready = 1;
    step();
    chk({tag, " ov_clear"}, ov, 0);
    chk({tag, " ready"}, ir, 1);
  endtask

  initial begin
    logic [127:0] blk [8];
    logic [127:0] exp [8];
    logic dec [8];
    int k, oc, cyc, last;
    logic acc, seen;
    init_sbox();
    repeat (2) step();
    chk("reset out_valid", ov4, 0);
    chk("reset busy", bz4, 0);
    chk("reset block_out", bo4, 0);
    reset = 0;
    step();
    chk("reset in_ready", ir4, 1);

    k4 = expand({KEY1, 128'h0}, 4);
    send(4, 0, PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "aes128");
    hs("aes128");

    k4 = expand({KUNG, 128'h0}, 4);
    send(4, 0, TT, 128'h29c3505f571420f6402299b31a02d73a, "kung enc");
    hs("kung enc");
    send(4, 1, 128'h29c3505f571420f6402299b31a02d73a, TT, "kung dec");
    hs("kung dec");

    k6 = expand({K192, 64'h0}, 6);
    send(6, 0, PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "aes192 enc");
    hs("aes192 enc");
    send(6, 1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, "aes192 dec");
    hs("aes192 dec");

    k8 = expand(K256, 8);
    out_ready = 0;
    send(8, 0, PT, 128'h8ea2b7ca516745bfeafc49904b496089, "aes256");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        iv8 = 1;
        block_in = ~PT;
        decrypt = 1;
      end
      step();
      chk("stall block_out", bo8, 128'h8ea2b7ca516745bfeafc49904b496089);
      chk("stall in_ready", ir8, 0);
      chk("stall out_valid", ov8, 1);
    end
    iv8 = 0;
    hs("stall release");
    repeat (3) step();
    chk("ignored busy", bz8, 0);
    chk("ignored out_valid", ov8, 0);

    k4 = expand({KEY1, 128'h0}, 4);
    sel = 4;
    decrypt = 0;
    block_in = PT;
    iv4 = 1;
    step();
    iv4 = 0;
    repeat (5) step();
    #2 reset = 1;
    #1;
    chk("abort out_valid", ov4, 0);
    chk("abort busy", bz4, 0);
    chk("abort block_out", bo4, 0);
    step();
    #2 reset = 0;
    seen = 0;
    repeat (20) begin
      step();
      seen = seen | ov4;
    end
    chk("abort never valid", seen, 0);
    chk("abort in_ready", ir4, 1);
    send(4, 0, PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "after reset");
    hs("after reset");

    for (int i = 0; i < 8; i += 2) begin
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
      dec[i] = 0;
      exp[i] = aes_enc(blk[i], k4, 10);
      blk[i+1] = exp[i];
      dec[i+1] = 1;
      exp[i+1] = blk[i];
    end
    out_ready = 1;
    sel = 4;
    k = 0;
    oc = 0;
    cyc = 0;
    last = 0;
    decrypt = dec[0];
    block_in = blk[0];
    iv4 = 1;
    while ((k < 8 || oc < 8) && cyc < 200) begin
      acc = iv4 && ir4;
      step();
      cyc++;
      if (acc) begin
        if (k > 0) chk("stream spacing", cyc - last, 12);
        last = cyc;
        k++;
        if (k < 8) begin
          decrypt = dec[k];
          block_in = blk[k];
        end else iv4 = 0;
      end
      if (ov4 && oc < 8) begin
        chk("stream result", bo4, exp[oc]);
        oc++;
      end
    end
    chk("stream accepted", k, 8);
    chk("stream results", oc, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Iterative, parameterised AES round engine for AES-128, AES-192 and AES-256. It runs either the forward cipher or the inverse cipher, one round per clock. It sits between the key-expansion block, which supplies the full precomputed `keySchedule`, and the system datapath. It uses a valid/ready handshake on both the input and output sides, so it replaces the free-running, toggle-restarted encrypt loop.

## Interface
- `NK`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8. Any other value is a elaboration error.
- `NR`, default `NK+6`: number of rounds. It is derived and must not be overridden.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `decrypt` in 1: mode bit, sampled with `in_valid`. 0 selects the forward cipher, 1 selects the inverse cipher.
- `in_valid` in 1: a block is presented.
- `in_ready` out 1: the engine accepts a block this cycle.
- `block_in` in [0:127]: plaintext or ciphertext. Bit 0 is the MSB of byte 0.
- `keySchedule` in [0:128*(NR+1)-1]: round keys rk[0..NR]. Round key j occupies bits `128*j +: 128`. It must be held stable from acceptance until the output handshake completes.
- `out_valid` out 1: `block_out` holds a finished result.
- `out_ready` in 1: the consumer takes the result.
- `block_out` out [0:127]: the result register.
- `busy` out 1: high while rounds are in progress.

## Operation
- The engine reuses the team's existing combinational round blocks:
  - addRoundKey
  - encryptRound and encryptLastRound
  - decryptRound and decryptLastRound
- Registers:
  - 128-bit `state`.
  - Round counter `rnd`, 4 bits. This is wide enough for NR=14.
  - Latched `mode` bit.
  - 2-bit FSM.
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE: `in_ready`=1. On `in_valid`:
    - Latch `mode` from `decrypt`.
    - Load `state` with `block_in` XOR rk[0] when encrypting, or with `block_in` XOR rk[NR] when decrypting.
    - Set `rnd` to 1 and go to ROUND.
  - ROUND: apply a full round using key rk[rnd] when encrypting, or rk[NR-rnd] when decrypting. Increment `rnd`. When `rnd` reaches NR-1 in this cycle, go to FINAL.
  - FINAL: apply the last round, which has no MixColumns / InvMixColumns. The key is rk[NR] when encrypting, or rk[0] when decrypting. Write the result to `block_out`, set `out_valid`, and go to DONE.
  - DONE: hold `block_out` and `out_valid`. When `out_ready`=1, clear `out_valid` and return to IDLE.
- `in_ready` is high only in IDLE. `in_valid` in any other state is ignored and its block is not queued.
- `busy` is high in ROUND and FINAL.
- `block_out` changes only on the FINAL edge. It keeps its last value after the handshake completes.
- `decrypt`, `block_in` and `in_valid` are don't-care outside the acceptance cycle. `mode` stays frozen until the next acceptance.
- Reset values:
  - FSM = IDLE and `rnd` = 0.
  - `state` = 0 and `block_out` = 0.
  - `out_valid` = 0 and `busy` = 0.
  - `in_ready` = 1 once reset is deasserted.
- Reset asserted mid-operation aborts the block. No partial result appears. The first block after reset behaves exactly like the first block after power-up.

## Timing
- Acceptance edge E0: `in_valid` and `in_ready` both high.
- Round edges are E1 through E(NR-1). The FINAL edge is E(NR).
- `out_valid` rises right after E(NR). Latency from acceptance edge to `out_valid` is NR edges:
  - 10 for NK=4.
  - 12 for NK=6.
  - 14 for NK=8.
- Output handshake at edge Ed, with `out_valid` and `out_ready` both high. The FSM is in IDLE after Ed.
  - The earliest next acceptance is Ed+1.
  - Peak throughput is one block per NR+2 cycles when `out_ready` is held high.
- If `out_ready` is already high when `out_valid` rises, the handshake completes on the next edge. There is no combinational path from `out_ready` to `in_ready`.
- Back-pressure: `out_valid` can be held indefinitely. `block_out` must stay bit-stable throughout.

## Test plan
- NK=4, encrypt, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: `block_out`=69c4e0d86a7b0430d8cdb78070b4c55a.
  - `out_valid` rises exactly 10 edges after acceptance. `busy` is high for those 10 cycles.
- NK=4, key "Thats my Kung Fu" (5468617473206d79204b756e67204675), pt 54776f204f6e65204e696e652054776f.
  - Encrypt: result must be 29c3505f571420f6402299b31a02d73a.
  - Decrypt that result: must return the plaintext.
- NK=6, key 000102…1617, same pt.
  - Encrypt: dda97ca4864cdfe06eaf70a0ec0d7191, with latency 12.
  - Decrypt that value: must return the pt.
- NK=8, key 000102…1e1f, same pt.
  - Encrypt: 8ea2b7ca516745bfeafc49904b496089, with latency 14.
  - Hold `out_ready`=0 for 20 cycles. `block_out` must stay stable, `in_ready` must stay 0, and a second `in_valid` must be ignored.
- Assert `reset` asynchronously at round 5 of an encryption.
  - All outputs must clear immediately and `out_valid` must never assert for the aborted block.
  - A following encrypt of the test 1 vector must give the correct result with normal latency.
- Back-to-back stream of 8 random blocks, with `out_ready` tied high and mode alternating.
  - Every result must match the reference model.
  - Acceptances must occur every NR+2 cycles.
